ca_word_loader: RTL and testbench

Writer side of the cellular-automaton load interface: the block that drives a 512-cell engine's load/data inputs.
- Accepts the initial cell state as a stream of narrow words over a valid/ready handshake.
- Assembles the words into a full-width state vector.
- Drives a load pulse that commits the vector into the CA engine.
- Reports how many generations the engine has run since the last commit.

---
 rtl/ca_pkg.sv | 18 +
 rtl/ca_gen_counter.sv | 36 +++
 rtl/ca_word_loader.sv | 175 +++++++++++++++++
 tb/tb_ca_word_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ca_pkg.sv
// ca_pkg: shared types and constants for the cellular-automaton word loader.
//   CA_STATE_W     default number of CA cells (width of the engine data bus)
//   CA_WORD_W      default width of one input word
//   ca_ldr_state_t loader state: FILL (accepting words) / COMMIT (driving load)
//   ca_state_t     full-width CA state vector at the default width
package ca_pkg;

    localparam int CA_STATE_W = 512;
    localparam int CA_WORD_W  = 32;

    typedef enum logic {
        FILL   = 1'b0,
        COMMIT = 1'b1
    } ca_ldr_state_t;

    typedef logic [CA_STATE_W-1:0] ca_state_t;

endpackage

// File: rtl/ca_gen_counter.sv
// ca_gen_counter: saturating up-counter with synchronous clear.
// Ports:
//   clk      clock, all logic on posedge
//   reset    synchronous active-high reset (count -> 0)
//   i_clr    synchronous clear, has priority over i_inc
//   i_inc    increment by one; holds at all-ones instead of wrapping
//   o_count  current count
module ca_gen_counter
    import ca_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values, independent of statement order between blocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ca_word_loader.sv
// ca_word_loader: writer side of the CA engine load interface. Collects
// STATE_W/WORD_W words (word 0 first) over a valid/ready handshake into a
// shadow vector, then publishes it on data together with a LOAD_CYCLES-long
// load pulse, and counts generations run since load last dropped.
// Optional framing check: define CA_LOADER_LAST_CHECK_EN to validate in_last
// against the word count and pulse err_frame on a mismatch; without it
// in_last is ignored and err_frame is tied low.
// Ports:
//   clk        clock, all logic on posedge
//   reset      synchronous active-high reset
//   in_valid   input word available
//   in_data    input word, word i lands in data[i*WORD_W +: WORD_W]
//   in_last    end-of-frame marker (framing check only)
//   in_ready   word accepted this cycle when in_valid is also high
//   load       load strobe to the CA engine
//   data       state vector to the CA engine
//   busy       frame partly received or commit in progress
//   gen_count  generations elapsed since load last deasserted (saturating)
//   err_frame  one-cycle framing error pulse
module ca_word_loader
    import ca_pkg::*;
#(
    parameter int STATE_W     = CA_STATE_W,
    parameter int WORD_W      = CA_WORD_W,
    parameter int LOAD_CYCLES = 1,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               load,
    output logic [STATE_W-1:0] data,
    output logic               busy,
    output logic [CNT_W-1:0]   gen_count,
    output logic               err_frame
);

    localparam int NWORDS = STATE_W / WORD_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [3:0]       CC_INIT  = 4'(LOAD_CYCLES - 1);

    generate
        if ((STATE_W % WORD_W) != 0) begin : g_bad_word_w
            $fatal(1, "ca_word_loader: STATE_W must be a multiple of WORD_W");
        end
        if ((LOAD_CYCLES < 1) || (LOAD_CYCLES > 15)) begin : g_bad_load_cycles
            $fatal(1, "ca_word_loader: LOAD_CYCLES must be in 1..15");
        end
    endgenerate

    ca_ldr_state_t      r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [STATE_W-1:0] r_shadow;
    logic [STATE_W-1:0] r_data;
    logic               r_load;
    logic [3:0]         r_cc;

    logic [STATE_W-1:0] w_merged;
    logic               w_accept;
    logic               w_final;
    logic               w_discard;
    logic               w_bad_end;
    logic               w_commit_end;
    logic               w_load_next;

    assign in_ready = (r_state == FILL);
    assign w_accept = in_valid && in_ready;
    assign w_final  = (r_idx == LAST_IDX);

`ifdef CA_LOADER_LAST_CHECK_EN
    // Early in_last abandons the frame; a missing in_last on the final word
    // is flagged but the frame still commits.
    assign w_discard = w_accept && in_last && !w_final;
    assign w_bad_end = w_accept && !in_last && w_final;

    logic r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_discard || w_bad_end;
        end
    end

    assign err_frame = r_err;
`else
    assign w_discard = 1'b0;
    assign w_bad_end = 1'b0;
    assign err_frame = 1'b0;

    logic w_unused;
    assign w_unused = in_last ^ w_bad_end;
`endif

    // NOTE: a combinational block assigns every output first, then refines;
    // without the default the partial-slice update would infer a latch.
    always_comb begin
        w_merged = r_shadow;
        w_merged[int'(r_idx) * WORD_W +: WORD_W] = in_data;
    end

    // NOTE: the shadow vector is reset (not left as uninitialised storage)
    // because a discarded partial frame must not leak into a later commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= FILL;
            r_idx    <= '0;
            r_shadow <= '0;
            r_data   <= '0;
            r_load   <= 1'b0;
            r_cc     <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (w_discard) begin
                            r_idx    <= '0;
                            r_shadow <= '0;
                        end else if (w_final) begin
                            // data and load both flip on this edge so the
                            // engine sees a consistent vector with the strobe.
                            r_data   <= w_merged;
                            r_shadow <= w_merged;
                            r_idx    <= '0;
                            r_load   <= 1'b1;
                            r_cc     <= CC_INIT;
                            r_state  <= COMMIT;
                        end else begin
                            r_shadow <= w_merged;
                            r_idx    <= r_idx + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    if (r_cc == 4'd0) begin
                        r_load  <= 1'b0;
                        r_state <= FILL;
                    end else begin
                        r_cc <= r_cc - 4'd1;
                    end
                end
                default: begin
                    r_state <= FILL;
                    r_load  <= 1'b0;
                end
            endcase
        end
    end

    assign w_commit_end = (r_state == COMMIT) && (r_cc == 4'd0);
    // Next-cycle value of load; the counter tracks it so gen_count reads 0 in
    // every cycle load is high and starts at 1 in the first cycle after.
    assign w_load_next  = (w_accept && w_final && !w_discard) ||
                          ((r_state == COMMIT) && !w_commit_end);

    ca_gen_counter #(
        .CNT_W (CNT_W)
    ) u_gen_counter (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_load_next),
        .i_inc   (!w_load_next),
        .o_count (gen_count)
    );

    assign load = r_load;
    assign data = r_data;
    assign busy = (r_state == COMMIT) || (r_idx != '0);

endmodule

// File: tb/tb_ca_word_loader.sv
// Bench for ca_word_loader: instance A at default widths (LOAD_CYCLES=1,
// with a Rule 110 engine model on its load/data), instance B small
// (64-bit state, LOAD_CYCLES=3, CNT_W=4). Expected frames for A are queued
// when their final word is driven and compared when load rises.
module tb_ca_word_loader;
    import ca_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default geometry
    logic        a_reset, a_valid, a_last, a_ready, a_load, a_busy, a_err;
    logic [31:0] a_wdata;
    logic [511:0] a_dout;
    logic [31:0] a_gen;

    // Instance B: 2 words, 3-cycle load, 4-bit counter
    logic        b_reset, b_valid, b_last, b_ready, b_load, b_busy, b_err;
    logic [31:0] b_wdata;
    logic [63:0] b_dout;
    logic [3:0]  b_gen;

    ca_word_loader #(
        .STATE_W(512), .WORD_W(32), .LOAD_CYCLES(1), .CNT_W(32)
    ) u_dut_a (
        .clk(clk), .reset(a_reset), .in_valid(a_valid), .in_data(a_wdata),
        .in_last(a_last), .in_ready(a_ready), .load(a_load), .data(a_dout),
        .busy(a_busy), .gen_count(a_gen), .err_frame(a_err)
    );

    ca_word_loader #(
        .STATE_W(64), .WORD_W(32), .LOAD_CYCLES(3), .CNT_W(4)
    ) u_dut_b (
        .clk(clk), .reset(b_reset), .in_valid(b_valid), .in_data(b_wdata),
        .in_last(b_last), .in_ready(b_ready), .load(b_load), .data(b_dout),
        .busy(b_busy), .gen_count(b_gen), .err_frame(b_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Rule 110 engine on instance A; bit i+1 is the left neighbour of bit i.
    function automatic logic [511:0] rule110(input logic [511:0] s);
        logic [511:0] n;
        logic [7:0]   rule;
        logic [2:0]   pat;
        rule = 8'd110;
        for (int i = 0; i < 512; i++) begin
            pat[2] = (i == 511) ? 1'b0 : s[i+1];
            pat[1] = s[i];
            pat[0] = (i == 0) ? 1'b0 : s[i-1];
            n[i]   = rule[pat];
        end
        return n;
    endfunction

    logic [511:0] eng_q = '0;
    always @(posedge clk) eng_q <= a_load ? a_dout : rule110(eng_q);

    // Scoreboard for instance A
    ca_state_t sb_q[$];
    logic      a_load_q = 1'b0;
    ca_state_t last_commit_a = '0;

    always @(negedge clk) begin
        if (a_load && !a_load_q) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_load", 1'b1, 1'b0);
            end else begin
                check("sb_frame_data", a_dout, sb_q.pop_front());
            end
        end
        a_load_q = a_load;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Offer one word to A and return at the negedge after it was accepted.
    task automatic put_word_a(input logic [31:0] w, input logic last);
        int guard = 0;
        a_valid = 1'b1;
        a_wdata = w;
        a_last  = last;
        while (!a_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("a_ready_wait", guard < 50, 1'b1);
        @(negedge clk);
        a_valid = 1'b0;
        a_last  = 1'b0;
        a_wdata = $urandom;
    endtask

    // Full 16-word frame to A; last_at selects which word carries in_last.
    task automatic send_frame_a(input ca_state_t f, input bit gap, input int last_at);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) sb_q.push_back(f);
            put_word_a(f[i*32 +: 32], (i == last_at));
            if (i < 15) begin
                check("busy_midframe", a_busy, 1'b1);
                check("data_stable", a_dout, last_commit_a);
                check("load_midframe", a_load, 1'b0);
                if (gap) begin
                    @(negedge clk);
                    check("ready_gap", a_ready, 1'b1);
                end
            end
        end
        check("load_rise", a_load, 1'b1);
        check("data_commit", a_dout, f);
        check("ready_commit", a_ready, 1'b0);
        check("busy_commit", a_busy, 1'b1);
        last_commit_a = f;
    endtask

    ca_state_t   frame;
    logic [31:0] w0, w1, wx, wy;

    initial begin
        a_reset = 1'b1; a_valid = 1'b0; a_last = 1'b0; a_wdata = '0;
        b_reset = 1'b1; b_valid = 1'b0; b_last = 1'b0; b_wdata = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_data", a_dout, '0);
        check("rst_load", a_load, 1'b0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_gen", a_gen, '0);
        check("rst_err", a_err, 1'b0);
        check("rst_ready", a_ready, 1'b1);
        check("rst_b_load", b_load, 1'b0);
        check("rst_b_data", b_dout, '0);
        a_reset = 1'b0;
        b_reset = 1'b0;
        @(negedge clk);
        check("gen_after_reset", a_gen, 32'd1);

        // Single seed cell, back-to-back words
        send_frame_a(512'h1, 1'b0, 15);
        check("gen_in_load", a_gen, '0);
        @(negedge clk);
        check("load_width", a_load, 1'b0);
        check("gen_first", a_gen, 32'd1);
        check("ready_after", a_ready, 1'b1);
        check("busy_after", a_busy, 1'b0);
        @(negedge clk);
        check("rule110_gen1", eng_q, 512'h3);
        check("gen_second", a_gen, 32'd2);

        // Same frame with idle cycles between words
        send_frame_a(512'h1, 1'b1, 15);
        @(negedge clk);
        check("load_width_gap", a_load, 1'b0);

        // Commit, then reset in the middle of the next frame
        send_frame_a(512'h4df, 1'b0, 15);
        @(negedge clk);
        for (int i = 0; i < 8; i++) put_word_a($urandom, 1'b0);
        check("data_hold_partial", a_dout, 512'h4df);
        a_reset = 1'b1;
        @(negedge clk);
        a_reset = 1'b0;
        check("midrst_data", a_dout, '0);
        check("midrst_load", a_load, 1'b0);
        check("midrst_busy", a_busy, 1'b0);
        check("midrst_gen", a_gen, '0);
        last_commit_a = '0;
        for (int i = 0; i < 16; i++) frame[i*32 +: 32] = $urandom;
        send_frame_a(frame, 1'b0, 15);
        @(negedge clk);

`ifdef CA_LOADER_LAST_CHECK_EN
        // Early in_last on word 4: frame dropped, error pulse
        for (int i = 0; i < 4; i++) put_word_a($urandom, 1'b0);
        put_word_a($urandom, 1'b1);
        check("early_last_err", a_err, 1'b1);
        check("early_last_load", a_load, 1'b0);
        check("early_last_busy", a_busy, 1'b0);
        check("early_last_data", a_dout, last_commit_a);
        @(negedge clk);
        check("early_last_err_pulse", a_err, 1'b0);
        check("early_last_noload", a_load, 1'b0);
        for (int i = 0; i < 16; i++) frame[i*32 +: 32] = $urandom;
        send_frame_a(frame, 1'b0, 15);
        check("good_frame_err", a_err, 1'b0);
        @(negedge clk);
        // Missing in_last on final word: error but still commits
        for (int i = 0; i < 16; i++) frame[i*32 +: 32] = $urandom;
        send_frame_a(frame, 1'b0, -1);
        check("missing_last_err", a_err, 1'b1);
        @(negedge clk);
        check("missing_last_err_pulse", a_err, 1'b0);
`else
        // in_last ignored: stray marker on word 4, none on the final word
        for (int i = 0; i < 16; i++) frame[i*32 +: 32] = $urandom;
        send_frame_a(frame, 1'b0, 4);
        check("nolast_err", a_err, 1'b0);
        @(negedge clk);
        check("nolast_err_after", a_err, 1'b0);
`endif

        // Instance B: 3-cycle commit, word offered during commit, saturation
        w0 = $urandom; w1 = $urandom; wx = $urandom; wy = $urandom;
        b_valid = 1'b1;
        b_wdata = w0;
        @(negedge clk);
        b_wdata = w1;
        @(negedge clk);
        b_wdata = wx;
        for (int c = 0; c < 3; c++) begin
            check("b_load_hold", b_load, 1'b1);
            check("b_ready_commit", b_ready, 1'b0);
            check("b_gen_commit", b_gen, 4'd0);
            check("b_data_commit", b_dout, {w1, w0});
            @(negedge clk);
        end
        check("b_load_drop", b_load, 1'b0);
        check("b_ready_fill", b_ready, 1'b1);
        check("b_gen_1", b_gen, 4'd1);
        check("b_busy_idle", b_busy, 1'b0);
        @(negedge clk);
        check("b_busy_accept", b_busy, 1'b1);
        check("b_gen_2", b_gen, 4'd2);
        b_valid = 1'b0;
        b_wdata = $urandom;
        for (int k = 3; k <= 22; k++) begin
            @(negedge clk);
            check("b_gen_sat", b_gen, (k > 15) ? 4'd15 : 4'(k));
        end
        check("b_data_stable", b_dout, {w1, w0});
        b_valid = 1'b1;
        b_wdata = wy;
        @(negedge clk);
        b_valid = 1'b0;
        check("b_load_2", b_load, 1'b1);
        check("b_data_2", b_dout, {wy, wx});
        check("b_gen_clr", b_gen, 4'd0);
        repeat (3) @(negedge clk);
        check("b_load_end", b_load, 1'b0);

        check("sb_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
